// File: rtl/trap_ctrl.sv
// trap_ctrl: picks one exception, xRET or interrupt, drains the pipe, strobes the commit into
// csr_regfile for one cycle and then holds the frontend redirect handshake until it is accepted.
module trap_ctrl #(
   parameter int XLEN         = 32,
   parameter int DRAIN_CYCLES = 2,   // legal range 1..15
   parameter int SYNC_STAGES  = 2    // legal range 2..3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            exc_valid,
   input  logic [4:0]      exc_code,
   input  logic [XLEN-1:0] exc_pc,
   input  logic            mret_req,
   input  logic            sret_req,
   input  logic            uret_req,
   input  logic            commit_valid,
   input  logic [XLEN-1:0] commit_pc,
   input  logic            ext_m_irq,
   input  logic            ext_s_irq,
   input  logic            m_timer,
   input  logic            s_timer,
   input  logic            m_eie,
   input  logic            m_tie,
   input  logic            s_eie,
   input  logic            s_tie,
   input  logic            redirect_ready,
   output logic            m_interrupt,
   output logic            s_interrupt,
   output logic            exception_pending,
   output logic [XLEN-1:0] cause,
   output logic [XLEN-1:0] pc_exc,
   output logic            m_ret,
   output logic            s_ret,
   output logic            u_ret,
   output logic            flush,
   output logic            stall_fetch,
   output logic            redirect_valid,
   output logic            busy
);

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      TRAP,
      REDIRECT
   } state_t;

   localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

   state_t            state;
   state_t            state_next;
   logic [3:0]        drain_cnt;
   logic [3:0]        drain_cnt_next;
   logic [2:0]        ret_kind;
   logic [2:0]        ret_kind_next;
   logic [XLEN-1:0]   cause_next;
   logic [XLEN-1:0]   pc_exc_next;
   logic [SYNC_STAGES-1:0] m_sync;
   logic [SYNC_STAGES-1:0] s_sync;
   logic              irq_any;
   logic [4:0]        irq_code;
   logic              ret_any;

   // External interrupt lines are asynchronous; only the last flop of each chain is used.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_sync <= '0;
         s_sync <= '0;
      end else begin
         m_sync <= {m_sync[SYNC_STAGES-2:0], ext_m_irq};
         s_sync <= {s_sync[SYNC_STAGES-2:0], ext_s_irq};
      end
   end

   assign m_interrupt = m_sync[SYNC_STAGES-1];
   assign s_interrupt = s_sync[SYNC_STAGES-1];

   assign irq_any = (m_interrupt & m_eie) | (m_timer & m_tie) |
                    (s_interrupt & s_eie) | (s_timer & s_tie);
   assign ret_any = mret_req | sret_req | uret_req;

   // Machine-level sources beat supervisor ones; external beats timer within a level.
   always_comb begin
      irq_code = 5'd0;
      if (m_interrupt & m_eie) begin
         irq_code = 5'd11;
      end else if (m_timer & m_tie) begin
         irq_code = 5'd7;
      end else if (s_interrupt & s_eie) begin
         irq_code = 5'd9;
      end else if (s_timer & s_tie) begin
         irq_code = 5'd5;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         drain_cnt <= '0;
         ret_kind  <= '0;
         cause     <= '0;
         pc_exc    <= '0;
      end else begin
         state     <= state_next;
         drain_cnt <= drain_cnt_next;
         ret_kind  <= ret_kind_next;
         cause     <= cause_next;
         pc_exc    <= pc_exc_next;
      end
   end

   // cause/pc_exc only change on a capture, so csr_regfile sees them stable through the whole sequence.
   always_comb begin
      state_next        = state;
      drain_cnt_next    = drain_cnt;
      ret_kind_next     = ret_kind;
      cause_next        = cause;
      pc_exc_next       = pc_exc;
      exception_pending = 1'b0;
      flush             = 1'b0;
      stall_fetch       = 1'b0;
      redirect_valid    = 1'b0;
      m_ret             = 1'b0;
      s_ret             = 1'b0;
      u_ret             = 1'b0;

      case (state)
         IDLE: begin
            if (exc_valid) begin
               cause_next     = {{(XLEN-5){1'b0}}, exc_code};
               pc_exc_next    = exc_pc;
               ret_kind_next  = 3'b000;
               drain_cnt_next = DRAIN_INIT;
               state_next     = DRAIN;
            end else if (ret_any) begin
               ret_kind_next  = {mret_req, sret_req, uret_req};
               drain_cnt_next = DRAIN_INIT;
               state_next     = DRAIN;
            end else if (irq_any && commit_valid) begin
               cause_next     = {1'b1, {(XLEN-6){1'b0}}, irq_code};
               pc_exc_next    = commit_pc;
               ret_kind_next  = 3'b000;
               drain_cnt_next = DRAIN_INIT;
               state_next     = DRAIN;
            end
         end
         DRAIN: begin
            flush       = 1'b1;
            stall_fetch = 1'b1;
            if (drain_cnt == 4'd0) begin
               state_next = TRAP;
            end else begin
               drain_cnt_next = drain_cnt - 4'd1;
            end
         end
         TRAP: begin
            exception_pending = 1'b1;
            flush             = 1'b1;
            stall_fetch       = 1'b1;
            {m_ret, s_ret, u_ret} = ret_kind;
            state_next        = REDIRECT;
         end
         REDIRECT: begin
            redirect_valid = 1'b1;
            stall_fetch    = 1'b1;
            {m_ret, s_ret, u_ret} = ret_kind;
            if (redirect_ready) begin
               state_next = IDLE;
            end
         end
      endcase
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed capture table, hand-written corner sequences and a randomized run
// compared against a cycle-age model of the trap sequence.
module tb_trap_ctrl;

   localparam int XLEN = 32;
   localparam int D    = 2;
   localparam int S    = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            exc_valid;
   logic [4:0]      exc_code;
   logic [XLEN-1:0] exc_pc;
   logic            mret_req, sret_req, uret_req;
   logic            commit_valid;
   logic [XLEN-1:0] commit_pc;
   logic            ext_m_irq, ext_s_irq;
   logic            m_timer, s_timer, m_eie, m_tie, s_eie, s_tie;
   logic            redirect_ready;
   logic            m_interrupt, s_interrupt, exception_pending;
   logic [XLEN-1:0] cause, pc_exc;
   logic            m_ret, s_ret, u_ret, flush, stall_fetch, redirect_valid, busy;

   int errors = 0;
   int checks = 0;

   trap_ctrl #(.XLEN(XLEN), .DRAIN_CYCLES(D), .SYNC_STAGES(S)) dut (
      .clk(clk), .rst(rst),
      .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
      .mret_req(mret_req), .sret_req(sret_req), .uret_req(uret_req),
      .commit_valid(commit_valid), .commit_pc(commit_pc),
      .ext_m_irq(ext_m_irq), .ext_s_irq(ext_s_irq),
      .m_timer(m_timer), .s_timer(s_timer),
      .m_eie(m_eie), .m_tie(m_tie), .s_eie(s_eie), .s_tie(s_tie),
      .redirect_ready(redirect_ready),
      .m_interrupt(m_interrupt), .s_interrupt(s_interrupt),
      .exception_pending(exception_pending), .cause(cause), .pc_exc(pc_exc),
      .m_ret(m_ret), .s_ret(s_ret), .u_ret(u_ret),
      .flush(flush), .stall_fetch(stall_fetch),
      .redirect_valid(redirect_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        exc_valid;
      logic [4:0]  exc_code;
      logic [31:0] exc_pc;
      logic [2:0]  ret;        // {mret, sret, uret}
      logic        commit_valid;
      logic [31:0] commit_pc;
      logic [3:0]  timers;     // {m_timer, m_tie, s_timer, s_tie}
      logic        exp_capture;
      logic [31:0] exp_cause;
      logic [31:0] exp_pc;
      logic [2:0]  exp_ret;
   } vec_t;

   vec_t vecs[12];

   // Reference model: sequence position is tracked as the number of edges since capture.
   bit          mb_busy;
   int          m_age;
   logic [31:0] mc, mp;
   logic [2:0]  mr;
   bit          m_q[$];
   bit          s_q[$];

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      exc_valid = 0; exc_code = '0; exc_pc = '0;
      mret_req = 0; sret_req = 0; uret_req = 0;
      commit_valid = 0; commit_pc = '0;
      ext_m_irq = 0; ext_s_irq = 0;
      m_timer = 0; s_timer = 0; m_eie = 0; m_tie = 0; s_eie = 0; s_tie = 0;
      redirect_ready = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #3;
      rst = 1'b0;
      tick();
   endtask

   // Walks one capture from IDLE through DRAIN, TRAP and REDIRECT back to IDLE.
   task automatic apply_stimulus(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("vec%0d", idx);
      clear_inputs();
      exc_valid = v.exc_valid; exc_code = v.exc_code; exc_pc = v.exc_pc;
      {mret_req, sret_req, uret_req} = v.ret;
      commit_valid = v.commit_valid; commit_pc = v.commit_pc;
      {m_timer, m_tie, s_timer, s_tie} = v.timers;
      tick();
      clear_inputs();
      if (v.exp_capture) begin
         check_output({tag, "_busy"}, 32'(busy), 32'd1);
         for (int i = 0; i < D; i++) begin
            check_output({tag, "_drain_pend"}, 32'(exception_pending), 32'd0);
            check_output({tag, "_drain_flush"}, 32'(flush), 32'd1);
            tick();
         end
         check_output({tag, "_pending"}, 32'(exception_pending), 32'd1);
         check_output({tag, "_cause"}, cause, v.exp_cause);
         check_output({tag, "_pc_exc"}, pc_exc, v.exp_pc);
         check_output({tag, "_trap_ret"}, 32'({m_ret, s_ret, u_ret}), 32'(v.exp_ret));
         tick();
         check_output({tag, "_redir_pend"}, 32'(exception_pending), 32'd0);
         check_output({tag, "_redir_ret"}, 32'({m_ret, s_ret, u_ret}), 32'(v.exp_ret));
         tick();
         check_output({tag, "_redir_hold"}, 32'(redirect_valid), 32'd1);
         redirect_ready = 1'b1;
         tick();
         redirect_ready = 1'b0;
         check_output({tag, "_idle"}, 32'({busy, redirect_valid, stall_fetch}), 32'd0);
      end else begin
         check_output({tag, "_nocap_busy"}, 32'(busy), 32'd0);
         check_output({tag, "_nocap_cause"}, cause, v.exp_cause);
         check_output({tag, "_nocap_pc"}, pc_exc, v.exp_pc);
      end
   endtask

   task automatic model_reset();
      mb_busy = 0; m_age = 0; mc = '0; mp = '0; mr = '0;
      m_q.delete(); s_q.delete();
      for (int i = 0; i < S; i++) begin
         m_q.push_back(1'b0);
         s_q.push_back(1'b0);
      end
   endtask

   task automatic model_step();
      bit mi, si;
      int code;
      mi = m_q[0];
      si = s_q[0];
      if (!mb_busy) begin
         code = -1;
         if (mi && m_eie) code = 11;
         else if (m_timer && m_tie) code = 7;
         else if (si && s_eie) code = 9;
         else if (s_timer && s_tie) code = 5;
         if (exc_valid) begin
            mc = 32'(exc_code); mp = exc_pc; mr = 3'b000; mb_busy = 1; m_age = 1;
         end else if (mret_req || sret_req || uret_req) begin
            mr = {mret_req, sret_req, uret_req}; mb_busy = 1; m_age = 1;
         end else if (code >= 0 && commit_valid) begin
            mc = 32'h8000_0000 + 32'(code); mp = commit_pc; mr = 3'b000; mb_busy = 1; m_age = 1;
         end
      end else if (m_age <= D + 1) begin
         m_age++;
      end else if (redirect_ready) begin
         mb_busy = 0;
      end
      m_q.push_back(ext_m_irq); void'(m_q.pop_front());
      s_q.push_back(ext_s_irq); void'(s_q.pop_front());
   endtask

   task automatic model_compare();
      bit drain, trap, redir;
      logic [9:0] exp_ctrl;
      drain = mb_busy && (m_age <= D);
      trap  = mb_busy && (m_age == D + 1);
      redir = mb_busy && (m_age > D + 1);
      exp_ctrl = {m_q[0], s_q[0], trap, (trap || redir) ? mr : 3'b000,
                  drain || trap, mb_busy, redir, mb_busy};
      check_output("rand_ctrl",
                   32'({m_interrupt, s_interrupt, exception_pending, m_ret, s_ret, u_ret,
                        flush, stall_fetch, redirect_valid, busy}), 32'(exp_ctrl));
      check_output("rand_cause", cause, mc);
      check_output("rand_pc_exc", pc_exc, mp);
   endtask

   initial begin
      vecs[0]  = '{1'b1, 5'd2,  32'h100,        3'b000, 1'b0, 32'h0,   4'b0000, 1'b1, 32'h2,         32'h100,        3'b000};
      vecs[1]  = '{1'b1, 5'd5,  32'h200,        3'b100, 1'b0, 32'h0,   4'b0000, 1'b1, 32'h5,         32'h200,        3'b000};
      vecs[2]  = '{1'b0, 5'd0,  32'h0,          3'b010, 1'b0, 32'h0,   4'b0000, 1'b1, 32'h5,         32'h200,        3'b010};
      vecs[3]  = '{1'b0, 5'd0,  32'h0,          3'b000, 1'b1, 32'h204, 4'b1100, 1'b1, 32'h8000_0007, 32'h204,        3'b000};
      vecs[4]  = '{1'b0, 5'd0,  32'h0,          3'b000, 1'b0, 32'h208, 4'b1100, 1'b0, 32'h8000_0007, 32'h204,        3'b000};
      vecs[5]  = '{1'b0, 5'd0,  32'h0,          3'b000, 1'b1, 32'h300, 4'b1011, 1'b1, 32'h8000_0005, 32'h300,        3'b000};
      vecs[6]  = '{1'b0, 5'd0,  32'h0,          3'b001, 1'b0, 32'h0,   4'b0000, 1'b1, 32'h8000_0005, 32'h300,        3'b001};
      vecs[7]  = '{1'b0, 5'd0,  32'h0,          3'b100, 1'b1, 32'h400, 4'b1100, 1'b1, 32'h8000_0005, 32'h300,        3'b100};
      vecs[8]  = '{1'b0, 5'd0,  32'h0,          3'b000, 1'b1, 32'h404, 4'b1111, 1'b1, 32'h8000_0007, 32'h404,        3'b000};
      vecs[9]  = '{1'b1, 5'd31, 32'hFFFF_FFFC,  3'b000, 1'b1, 32'h500, 4'b1111, 1'b1, 32'h1F,        32'hFFFF_FFFC,  3'b000};
      vecs[10] = '{1'b0, 5'd0,  32'h0,          3'b000, 1'b1, 32'h600, 4'b0101, 1'b0, 32'h1F,        32'hFFFF_FFFC,  3'b000};
      vecs[11] = '{1'b0, 5'd0,  32'h0,          3'b000, 1'b1, 32'h10,  4'b0011, 1'b1, 32'h8000_0005, 32'h10,         3'b000};

      clear_inputs();
      #2;
      check_output("reset_outputs",
                   32'({m_interrupt, s_interrupt, exception_pending, m_ret, s_ret, u_ret,
                        flush, stall_fetch, redirect_valid, busy}), 32'd0);
      check_output("reset_cause", cause, 32'd0);
      check_output("reset_pc_exc", pc_exc, 32'd0);
      do_reset();

      foreach (vecs[i]) apply_stimulus(vecs[i], i);

      // Synchronised machine external interrupt beats the machine timer, and only at a commit boundary.
      clear_inputs();
      ext_m_irq = 1; m_eie = 1; m_timer = 1; m_tie = 1;
      tick();
      check_output("sync_lat_1", 32'(m_interrupt), 32'd0);
      tick();
      check_output("sync_lat_2", 32'(m_interrupt), 32'd1);
      tick();
      check_output("irq_no_commit", 32'(busy), 32'd0);
      commit_valid = 1; commit_pc = 32'h204;
      tick();
      commit_valid = 0;
      check_output("irq_capture", 32'(busy), 32'd1);
      for (int i = 0; i < D; i++) tick();
      check_output("mei_pending", 32'(exception_pending), 32'd1);
      check_output("mei_cause", cause, 32'h8000_000B);
      check_output("mei_pc_exc", pc_exc, 32'h204);
      clear_inputs();
      tick();
      redirect_ready = 1;
      tick();
      redirect_ready = 0;

      // Redirect stalled for ten cycles while execute keeps reporting exceptions.
      clear_inputs();
      exc_valid = 1; exc_code = 5'd4; exc_pc = 32'h500;
      tick();
      exc_code = 5'd3; exc_pc = 32'h999;
      for (int i = 0; i < D + 1; i++) tick();
      for (int i = 0; i < 10; i++) begin
         tick();
         check_output("hold_busy", 32'({busy, redirect_valid, exception_pending}), 32'b110);
         check_output("hold_cause", cause, 32'h4);
      end
      exc_valid = 0;
      redirect_ready = 1;
      tick();
      redirect_ready = 0;
      check_output("hold_release", 32'(busy), 32'd0);
      check_output("hold_pc_exc", pc_exc, 32'h500);

      // Reset asserted mid-DRAIN aborts the sequence immediately.
      exc_valid = 1; exc_code = 5'd6; exc_pc = 32'h700;
      tick();
      clear_inputs();
      check_output("abort_in_drain", 32'(flush), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check_output("abort_outputs",
                   32'({exception_pending, m_ret, s_ret, u_ret, flush, stall_fetch, redirect_valid, busy}),
                   32'd0);
      check_output("abort_cause", cause, 32'd0);
      check_output("abort_pc_exc", pc_exc, 32'd0);
      #2;
      rst = 1'b0;
      for (int i = 0; i < D + 3; i++) begin
         tick();
         check_output("abort_no_pending", 32'({exception_pending, busy}), 32'd0);
      end

      // Randomized traffic against the reference model.
      clear_inputs();
      model_reset();
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         int r;
         exc_valid    = ($urandom_range(0, 7) == 0);
         exc_code     = 5'($urandom);
         exc_pc       = $urandom;
         r            = int'($urandom_range(0, 11));
         mret_req     = (r == 0);
         sret_req     = (r == 1);
         uret_req     = (r == 2);
         commit_valid = 1'($urandom_range(0, 1));
         commit_pc    = $urandom;
         if ($urandom_range(0, 15) == 0) ext_m_irq = ~ext_m_irq;
         if ($urandom_range(0, 15) == 0) ext_s_irq = ~ext_s_irq;
         m_timer = ($urandom_range(0, 3) == 0);
         s_timer = ($urandom_range(0, 3) == 0);
         m_eie   = 1'($urandom_range(0, 1));
         m_tie   = 1'($urandom_range(0, 1));
         s_eie   = 1'($urandom_range(0, 1));
         s_tie   = 1'($urandom_range(0, 1));
         redirect_ready = ($urandom_range(0, 2) == 0);
         @(posedge clk);
         model_step();
         #1;
         model_compare();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
